lcd_write_arbiter: RTL and testbench
====================================

// Module: lcd_write_arbiter
// PURPOSE
//  Shares the LCD character-buffer write port (DEVICE/DATA command bus, device 16'h0071) between two requesters.
//  Typical requesters are the CPU I/O path and a status/debug source.
//  Grants round-robin, with an optional per-requester lock for multi-character strings.
//  Paces each write: the command is held for HOLD_CYCLES, then an idle GAP_CYCLES follows,
//  so the LCD buffer (sampled on negedge clk_LCD) captures every character exactly once.
// PARAMETERS
//  LCD_DEV_ADDR  16'h0071  device code driven on dev_out during a write
//  HOLD_CYCLES   2         cycles a command is driven; must be >=1
//  GAP_CYCLES    1         cycles of dev_out=16'h0000 after each command; may be 0
// PORTS
//  clk_LCD    in   1   single clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  req        in   2   req[i]: requester i has a command word pending
//  req_word0  in   16  requester 0 word: [15]=line, [14:11]=column, [10:8]=0, [7:0]=char
//  req_word1  in   16  requester 1 word, same format
//  lock       in   2   lock[i]: keep grant with i after its current write
//  ack        out  2   one-cycle pulse: word i captured
//  clr_req    in   1   request full-screen clear (used only with LCD_CLEAR_EN)
//  clr_busy   out  1   clear sequence in progress
//  dev_out    out  16  DEVICE bus to LCD block
//  data_out   out  16  DATA bus to LCD block
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; dev_out=0, data_out=0, ack=0, busy=0, clr_busy=0; last_grant=1 (req 0 wins first tie).
//    rst mid-write aborts it immediately; the aborted requester is not re-acked.
//  States and transitions:
//    IDLE -> ISSUE on grant.
//    ISSUE: dev_out=LCD_DEV_ADDR, data_out=latched word, for HOLD_CYCLES cycles.
//    ISSUE -> GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
//    GAP: dev_out=0, data_out held, for GAP_CYCLES cycles; then -> IDLE.
//    CLEAR: only with LCD_CLEAR_EN; see CONFIGURATION.
//  Sampling and handshake:
//    req is sampled only in IDLE. Cycle N: req seen in IDLE.
//    Cycle N+1: ack[g]=1, word latched, state=ISSUE, dev_out valid.
//    The requester holds req and its word until ack; it may re-assert req the cycle after ack.
//  Arbitration:
//    Both requesting: grant the one != last_grant. One requesting: grant it.
//    lock[last_grant]=1 in IDLE: only last_grant is eligible; the other waits even if last_grant is idle.
//    Starvation under a held lock is the lock holder's responsibility.
//  Throughput: one write per (1 + HOLD_CYCLES + GAP_CYCLES) cycles minimum; default 4.
//  Bits [10:8] of a word are forced to 0 on data_out.
//  Counter is $clog2(max(HOLD,GAP)+1) bits; it reloads on every state entry.
// CONFIGURATION
//  Macro LCD_CLEAR_EN:
//    Defined:
//      - clr_req is sampled in IDLE with priority over req, unless a lock is held.
//      - On acceptance, clr_busy=1 and the CLEAR state issues 32 writes of char 8'h20:
//        line0 cols 0..15, then line1 cols 0..15.
//      - Each write uses the same HOLD/GAP timing; no ack is produced.
//      - After the last GAP, clr_busy=0 and state returns to IDLE.
//      - clr_req during a clear is ignored.
//    Undefined: clr_req is ignored, clr_busy is tied 0, and the CLEAR state and its 5-bit index counter are absent.
// STRUCTURE
//  Package lcd_pkg:
//    - LCD_DEV_ADDR default, field positions (LINE_BIT=15, COL_MSB=14, COL_LSB=11), CHAR_SPACE=8'h20.
//    - State enum {IDLE, ISSUE, GAP, CLEAR}.
//  Sub-module lcd_rr_arbiter: 2-way round-robin with lock.
//    Inputs req, lock, en; outputs grant one-hot and grant_valid; owns last_grant.
//  Top holds the FSM, pacing counter, word latch and the clear sequencer.
// TESTING
//  1 Reset, then req0=1 with word 16'h0041: ack0 at N+1; dev_out=16'h0071, data_out=16'h0041 for 2 cycles;
//    dev_out=0 for 1 cycle; then busy=0.
//  2 req0 and req1 both held from reset (words 16'h8842 and 16'h0843): grants alternate 0,1,0;
//    each ack 4 cycles apart.
//  3 lock0=1 with req0 and req1 held: three consecutive grants to 0; drop lock0 -> next grant goes to 1.
//  4 rst asserted during ISSUE: next cycle dev_out=0, busy=0, no ack; then req1 is granted first after reset.
//  5 With LCD_CLEAR_EN, pulse clr_req: 32 writes; 1st data_out=16'h0020, 17th data_out=16'h8020,
//    32nd data_out=16'hF820. clr_busy is high for exactly 128 cycles; req0 is held off until the clear completes.
//  6 Without LCD_CLEAR_EN: clr_req pulse gives no bus activity and clr_busy stays 0.

Source files
------------

// File: rtl/lcd_write_arbiter_pkg.sv
// Shared constants, field positions, state encoding and word helpers
// for the LCD write-port arbiter.
package lcd_pkg;

    localparam logic [15:0] LCD_DEV_ADDR_DEFAULT = 16'h0071;

    localparam int LINE_BIT = 15;
    localparam int COL_MSB  = 14;
    localparam int COL_LSB  = 11;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam int         CLEAR_WRITES = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        CLEAR
    } state_t;

    // Bits between the column field and the character are reserved and must reach the LCD as 0.
    function automatic logic [15:0] mask_word(input logic [15:0] word);
        logic [15:0] masked;
        masked = word;
        masked[COL_LSB-1:8] = '0;
        return masked;
    endfunction

    function automatic logic [15:0] clear_word(input logic [4:0] idx);
        logic [15:0] word;
        word = {8'h00, CHAR_SPACE};
        word[LINE_BIT] = idx[4];
        word[COL_MSB:COL_LSB] = idx[3:0];
        return word;
    endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester handshake and LCD DEVICE/DATA bus bundle; the arbiter is the slave,
// the requesters/environment drive the master side.
interface lcd_write_arbiter_if;

    logic [1:0]  req;
    logic [15:0] req_word0;
    logic [15:0] req_word1;
    logic [1:0]  lock;
    logic [1:0]  ack;
    logic        clr_req;
    logic        clr_busy;
    logic [15:0] dev_out;
    logic [15:0] data_out;
    logic        busy;

    modport slave (
        input  req, req_word0, req_word1, lock, clr_req,
        output ack, clr_busy, dev_out, data_out, busy
    );

    modport master (
        output req, req_word0, req_word1, lock, clr_req,
        input  ack, clr_busy, dev_out, data_out, busy
    );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter with a per-requester lock that pins the grant
// to the most recent winner.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_valid,
    output logic       lock_active
);

    logic       last_grant;
    logic [1:0] eligible;

    // A held lock excludes the other requester even when the holder has nothing pending.
    always_comb begin
        lock_active = lock[last_grant];
        eligible    = req;
        if (lock_active) begin
            eligible = req & (last_grant ? 2'b10 : 2'b01);
        end
        if (eligible == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = eligible;
        end
        grant_valid = |grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (en && grant_valid) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Arbitrates and paces writes to the LCD character buffer (hold then gap per write).
// Define LCD_CLEAR_EN to add the 32-write full-screen clear sequencer.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter logic [15:0] LCD_DEV_ADDR = LCD_DEV_ADDR_DEFAULT,
    parameter int          HOLD_CYCLES  = 2,
    parameter int          GAP_CYCLES   = 1
) (
    input logic                clk_LCD,
    input logic                rst,
    lcd_write_arbiter_if.slave bus
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [15:0]      data_reg, data_next;
    logic [1:0]       ack_reg, ack_next;
    logic             write_done;
    logic             arb_en;
    logic [1:0]       grant;
    logic             grant_valid;
    logic             lock_active;

`ifdef LCD_CLEAR_EN
    logic       clr_active, clr_active_next;
    logic [4:0] clr_idx, clr_idx_next;
`else
    logic unused_clr_req;
    assign unused_clr_req = bus.clr_req;
`endif

    lcd_rr_arbiter u_arb (
        .clk        (clk_LCD),
        .rst        (rst),
        .req        (bus.req),
        .lock       (bus.lock),
        .en         (arb_en),
        .grant      (grant),
        .grant_valid(grant_valid),
        .lock_active(lock_active)
    );

    // The pacing counter is reloaded on every state entry and counts down to zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        data_next  = data_reg;
        ack_next   = 2'b00;
        arb_en     = 1'b0;
        write_done = 1'b0;
`ifdef LCD_CLEAR_EN
        clr_active_next = clr_active;
        clr_idx_next    = clr_idx;
`endif
        case (state)
            IDLE: begin
`ifdef LCD_CLEAR_EN
                if (bus.clr_req && !lock_active) begin
                    state_next      = CLEAR;
                    clr_active_next = 1'b1;
                    clr_idx_next    = '0;
                end else
`endif
                if (grant_valid) begin
                    arb_en     = 1'b1;
                    state_next = ISSUE;
                    cnt_next   = HOLD_LOAD;
                    ack_next   = grant;
                    data_next  = mask_word(grant[1] ? bus.req_word1 : bus.req_word0);
                end
            end
            ISSUE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (GAP_CYCLES > 0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    write_done = 1'b1;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    write_done = 1'b1;
                end
            end
`ifdef LCD_CLEAR_EN
            CLEAR: begin
                state_next = ISSUE;
                cnt_next   = HOLD_LOAD;
                data_next  = clear_word(clr_idx);
            end
`endif
            default: state_next = IDLE;
        endcase

        if (write_done) begin
            state_next = IDLE;
`ifdef LCD_CLEAR_EN
            if (clr_active) begin
                if (clr_idx == 5'(CLEAR_WRITES - 1)) begin
                    clr_active_next = 1'b0;
                end else begin
                    state_next   = CLEAR;
                    clr_idx_next = clr_idx + 5'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_LCD) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_reg <= '0;
            ack_reg  <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            data_reg <= data_next;
            ack_reg  <= ack_next;
        end
    end

`ifdef LCD_CLEAR_EN
    always_ff @(posedge clk_LCD) begin
        if (rst) begin
            clr_active <= 1'b0;
            clr_idx    <= '0;
        end else begin
            clr_active <= clr_active_next;
            clr_idx    <= clr_idx_next;
        end
    end

    assign bus.clr_busy = clr_active;
`else
    assign bus.clr_busy = 1'b0;
`endif

    assign bus.dev_out  = (state == ISSUE) ? LCD_DEV_ADDR : 16'h0000;
    assign bus.data_out = data_reg;
    assign bus.ack      = ack_reg;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter: expected writes are queued as stimulus
// is driven and popped at each observed write start on the LCD bus.
module tb_lcd_write_arbiter;

    localparam int          HOLD = 2;
    localparam int          GAP  = 1;
    localparam logic [15:0] DEV  = 16'h0071;

    typedef struct packed {
        logic [1:0]  ack;
        logic [15:0] data;
    } exp_t;

    logic clk_LCD = 1'b0;
    logic rst     = 1'b1;

    lcd_write_arbiter_if bus ();

    lcd_write_arbiter #(
        .LCD_DEV_ADDR(DEV),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk_LCD(clk_LCD),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_LCD = ~clk_LCD;

    exp_t        exp_q[$];
    int          starts[$];
    int          checks      = 0;
    int          failures    = 0;
    int          cycle_count = 0;
    int          writes_seen = 0;
    int          hold_run    = 0;
    logic [15:0] prev_dev    = 16'h0000;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [1:0] lock);
        bus.req       = req;
        bus.req_word0 = w0;
        bus.req_word1 = w1;
        bus.lock      = lock;
    endtask

    task automatic pushExpect(input logic [1:0] ack, input logic [15:0] data);
        exp_t e;
        e.ack  = ack;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic waitWrites(input int target, input int budget);
        int n;
        n = 0;
        while (writes_seen < target && n < budget) begin
            @(posedge clk_LCD);
            n++;
        end
        checkOutput("write_timeout", 32'(writes_seen >= target), 32'd1);
        #1;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk_LCD);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk_LCD) cycle_count <= cycle_count + 1;

    // Bus monitor: a write starts when dev_out rises to the device code.
    always @(negedge clk_LCD) begin
        exp_t e;
        logic write_start;
        if (rst) begin
            hold_run = 0;
            prev_dev = 16'h0000;
        end else begin
            write_start = (bus.dev_out == DEV) && (prev_dev != DEV);
            if (write_start) begin
                writes_seen++;
                starts.push_back(cycle_count);
                checkOutput("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("write_ack", 32'(bus.ack), 32'(e.ack));
                    checkOutput("write_data", 32'(bus.data_out), 32'(e.data));
                end
            end else if (bus.ack != 2'b00) begin
                checkOutput("stray_ack", 32'(bus.ack), 32'd0);
            end
            if (bus.dev_out != DEV && bus.dev_out != 16'h0000) begin
                checkOutput("dev_value", 32'(bus.dev_out), 32'd0);
            end
            if (bus.dev_out == DEV) begin
                hold_run++;
            end else begin
                if (prev_dev == DEV) begin
                    checkOutput("hold_len", 32'(hold_run), 32'(HOLD));
                end
                hold_run = 0;
            end
            prev_dev = bus.dev_out;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int busy_cycles;

        applyStimulus(2'b00, 16'h0000, 16'h0000, 2'b00);
        bus.clr_req = 1'b0;

        // Test 1: reset values, then a single write from requester 0.
        repeat (2) @(posedge clk_LCD);
        @(negedge clk_LCD);
        checkOutput("reset_dev", 32'(bus.dev_out), 32'h0);
        checkOutput("reset_data", 32'(bus.data_out), 32'h0);
        checkOutput("reset_ack", 32'(bus.ack), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_clr_busy", 32'(bus.clr_busy), 32'h0);
        @(posedge clk_LCD);
        #1 rst = 1'b0;
        pushExpect(2'b01, 16'h0041);
        applyStimulus(2'b01, 16'h0041, 16'h0000, 2'b00);
        @(negedge clk_LCD);
        checkOutput("t1_no_early_ack", 32'(bus.ack), 32'h0);
        @(posedge clk_LCD);
        #1 applyStimulus(2'b00, 16'h0000, 16'h0000, 2'b00);
        @(negedge clk_LCD);
        checkOutput("t1_ack", 32'(bus.ack), 32'h1);
        checkOutput("t1_dev_hold1", 32'(bus.dev_out), 32'h0071);
        checkOutput("t1_data_hold1", 32'(bus.data_out), 32'h0041);
        checkOutput("t1_busy", 32'(bus.busy), 32'h1);
        @(negedge clk_LCD);
        checkOutput("t1_dev_hold2", 32'(bus.dev_out), 32'h0071);
        checkOutput("t1_ack_pulse", 32'(bus.ack), 32'h0);
        @(negedge clk_LCD);
        checkOutput("t1_dev_gap", 32'(bus.dev_out), 32'h0);
        checkOutput("t1_data_gap", 32'(bus.data_out), 32'h0041);
        checkOutput("t1_busy_gap", 32'(bus.busy), 32'h1);
        @(negedge clk_LCD);
        checkOutput("t1_idle", 32'(bus.busy), 32'h0);
        @(posedge clk_LCD);
        #1;

        // Test 2: both requesters held from reset alternate 0,1,0 at four-cycle spacing.
        rst = 1'b1;
        applyStimulus(2'b11, 16'h8842, 16'h0843, 2'b00);
        pushExpect(2'b01, 16'h8842);
        pushExpect(2'b10, 16'h0843);
        pushExpect(2'b01, 16'h8842);
        base = writes_seen;
        repeat (2) @(posedge clk_LCD);
        #1 rst = 1'b0;
        waitWrites(base + 3, 30);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 2'b00);
        checkOutput("t2_spacing_a", 32'(starts[$-1] - starts[$-2]), 32'd4);
        checkOutput("t2_spacing_b", 32'(starts[$] - starts[$-1]), 32'd4);
        settle();

        // Test 3: lock0 keeps three grants on requester 0; dropping it hands over to 1.
        rst = 1'b1;
        applyStimulus(2'b11, 16'h2141, 16'h0843, 2'b01);
        repeat (3) pushExpect(2'b01, 16'h2041);
        pushExpect(2'b10, 16'h0843);
        base = writes_seen;
        repeat (2) @(posedge clk_LCD);
        #1 rst = 1'b0;
        waitWrites(base + 3, 30);
        applyStimulus(2'b11, 16'h2141, 16'h0843, 2'b00);
        waitWrites(base + 4, 20);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 2'b00);
        settle();

        // Test 4: reset during ISSUE aborts the write; requester 1 is served afterwards.
        rst = 1'b1;
        applyStimulus(2'b01, 16'h0041, 16'h0000, 2'b00);
        pushExpect(2'b01, 16'h0041);
        base = writes_seen;
        repeat (2) @(posedge clk_LCD);
        #1 rst = 1'b0;
        waitWrites(base + 1, 20);
        pushExpect(2'b10, 16'h8843);
        applyStimulus(2'b10, 16'h0041, 16'h8D43, 2'b00);
        rst = 1'b1;
        @(posedge clk_LCD);
        #1 rst = 1'b0;
        @(negedge clk_LCD);
        checkOutput("t4_abort_dev", 32'(bus.dev_out), 32'h0);
        checkOutput("t4_abort_busy", 32'(bus.busy), 32'h0);
        checkOutput("t4_abort_ack", 32'(bus.ack), 32'h0);
        checkOutput("t4_abort_data", 32'(bus.data_out), 32'h0);
        waitWrites(base + 2, 20);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 2'b00);
        settle();

`ifdef LCD_CLEAR_EN
        // Test 5: clear sequence of 32 space writes holds off a pending requester.
        base = writes_seen;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] idx;
            idx = i[4:0];
            pushExpect(2'b00, {idx[4], idx[3:0], 3'b000, 8'h20});
        end
        pushExpect(2'b01, 16'h0041);
        bus.clr_req = 1'b1;
        applyStimulus(2'b01, 16'h0041, 16'h0000, 2'b00);
        busy_cycles = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_LCD);
            if (bus.clr_busy) busy_cycles++;
            @(posedge clk_LCD);
            #1;
            bus.clr_req = (c == 50);
            if (writes_seen >= base + 33) applyStimulus(2'b00, 16'h0000, 16'h0000, 2'b00);
        end
        bus.clr_req = 1'b0;
        checkOutput("t5_clr_busy_len", 32'(busy_cycles), 32'd128);
        checkOutput("t5_write_count", 32'(writes_seen - base), 32'd33);
        settle();
`else
        // Test 6: without the clear feature a clr_req pulse does nothing.
        base = writes_seen;
        bus.clr_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_LCD);
            checkOutput("t6_clr_busy", 32'(bus.clr_busy), 32'h0);
            checkOutput("t6_busy", 32'(bus.busy), 32'h0);
            @(posedge clk_LCD);
            #1 bus.clr_req = 1'b0;
        end
        checkOutput("t6_no_writes", 32'(writes_seen - base), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
